// File: rtl/sync_fifo_thr.sv
// Synchronous FIFO with arbitrary depth, programmable almost-full/almost-empty
// thresholds, occupancy count and error pulses. Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_thr #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 8,
    parameter int AF_LEVEL   = DATA_DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    localparam int CNT_WIDTH = $clog2(DATA_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [CNT_WIDTH-1:0]  data_count,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int PTR_W = $clog2(DATA_DEPTH);
    localparam logic [PTR_W-1:0]     LAST_PTR = PTR_W'(DATA_DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] DEPTH_C  = CNT_WIDTH'(DATA_DEPTH);
    localparam logic [CNT_WIDTH-1:0] AF_C     = CNT_WIDTH'(AF_LEVEL);
    localparam logic [CNT_WIDTH-1:0] AE_C     = CNT_WIDTH'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_WIDTH-1:0]  count, count_next;
    logic                  wr_acc, rd_acc;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    always_comb begin
        count_next = count;
        if (wr_acc && !rd_acc)
            count_next = count + CNT_WIDTH'(1);
        else if (rd_acc && !wr_acc)
            count_next = count - CNT_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
            count        <= count_next;
            empty        <= (count_next == '0);
            full         <= (count_next == DEPTH_C);
            almost_empty <= (count_next <= AE_C);
            almost_full  <= (count_next >= AF_C);
            overflow     <= wr_en & full;
            underflow    <= rd_en & empty;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !rst) mem[wr_ptr] <= data_in;
    end

    assign data_count = count;

`ifdef SYNC_FIFO_FWFT_EN
    logic [DATA_WIDTH-1:0] last_word;

    // Remembers the most recently acknowledged word so the output holds while empty.
    always_ff @(posedge clk) begin
        if (rst)
            last_word <= '0;
        else if (rd_acc)
            last_word <= mem[rd_ptr];
    end

    assign data_out = empty ? last_word : mem[rd_ptr];
    assign rd_valid = ~empty;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
            rd_valid <= 1'b0;
        end else if (rd_acc) begin
            data_out <= mem[rd_ptr];
            rd_valid <= 1'b1;
        end else begin
            rd_valid <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_sync_fifo_thr.sv
// Drives a depth-8 and a depth-6 FIFO with identical stimulus and scores both
// against a queue-based model; a negedge monitor checks flags and read data.
module tb_sync_fifo_thr;
    logic       clk = 1'b0;
    logic       rst, wr_en, rd_en;
    logic [7:0] data_in;

    logic [7:0] dout [2];
    logic       rv [2], emp [2], ful [2], aem [2], afl [2], ovf [2], unf [2];
    logic [3:0] cnt8;
    logic [2:0] cnt6;
    int         cnt [2];

    assign cnt[0] = 32'(cnt8);
    assign cnt[1] = 32'(cnt6);

    sync_fifo_thr #(.DATA_WIDTH(8), .DATA_DEPTH(8)) u8 (
        .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
        .data_out(dout[0]), .rd_valid(rv[0]), .empty(emp[0]), .full(ful[0]),
        .almost_empty(aem[0]), .almost_full(afl[0]), .data_count(cnt8),
        .overflow(ovf[0]), .underflow(unf[0]));

    sync_fifo_thr #(.DATA_WIDTH(8), .DATA_DEPTH(6)) u6 (
        .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
        .data_out(dout[1]), .rd_valid(rv[1]), .empty(emp[1]), .full(ful[1]),
        .almost_empty(aem[1]), .almost_full(afl[1]), .data_count(cnt6),
        .overflow(ovf[1]), .underflow(unf[1]));

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    int         DEP [2] = '{8, 6};
    logic [7:0] q [2][$];
    exp_t       sb [2][$];
    logic       e_ovf [2], e_unf [2];
    int         cyc_n = 0;
    bit         armed = 0;
    int         vectors = 0, ncmp = 0, nerr = 0;

    function automatic void chk(string nm, int d, int act, int exp);
        ncmp++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s dut%0d cyc%0d got %0d want %0d", nm, d, cyc_n, act, exp);
        end
    endfunction

    // Reference model: the FIFO is just a queue bounded by its depth.
    always @(posedge clk) begin
        cyc_n++;
        armed = 1;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                q[d].delete();
                sb[d].delete();
                e_ovf[d] = 0;
                e_unf[d] = 0;
            end else begin
                bit isfull, isempty, wa, ra;
                logic [7:0] v;
                isfull  = (q[d].size() == DEP[d]);
                isempty = (q[d].size() == 0);
                wa = wr_en && !isfull;
                ra = rd_en && !isempty;
                e_ovf[d] = wr_en && isfull;
                e_unf[d] = rd_en && isempty;
                if (ra) begin
                    v = q[d].pop_front();
`ifndef SYNC_FIFO_FWFT_EN
                    sb[d].push_back('{v, cyc_n});
`endif
                end
                if (wa) q[d].push_back(data_in);
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int d = 0; d < 2; d++) begin
                int n;
                n = q[d].size();
                chk("count", d, cnt[d], n);
                chk("empty", d, int'(emp[d]), int'(n == 0));
                chk("full", d, int'(ful[d]), int'(n == DEP[d]));
                chk("almost_empty", d, int'(aem[d]), int'(n <= 2));
                chk("almost_full", d, int'(afl[d]), int'(n >= DEP[d] - 2));
                chk("overflow", d, int'(ovf[d]), int'(e_ovf[d]));
                chk("underflow", d, int'(unf[d]), int'(e_unf[d]));
`ifdef SYNC_FIFO_FWFT_EN
                chk("rd_valid", d, int'(rv[d]), int'(n != 0));
                if (n != 0) chk("data_out", d, int'(dout[d]), int'(q[d][0]));
`else
                if (sb[d].size() != 0 && sb[d][0].cyc == cyc_n) begin
                    exp_t e;
                    e = sb[d].pop_front();
                    chk("rd_valid", d, int'(rv[d]), 1);
                    chk("data_out", d, int'(dout[d]), int'(e.data));
                end else begin
                    chk("rd_valid", d, int'(rv[d]), 0);
                end
`endif
            end
        end
    end

    task automatic cyc(input bit w, input bit r, input logic [7:0] din, input bit rs);
        @(negedge clk);
        wr_en   = w;
        rd_en   = r;
        data_in = din;
        rst     = rs;
        vectors++;
    endtask

    initial begin
        int wp, rp;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = 8'h00;
        cyc(0, 0, 8'h00, 1);
        cyc(0, 0, 8'h00, 1);
        cyc(0, 0, 8'h00, 0);
        // fill with 0x11..0x88, then push 0x99 while full
        for (int i = 1; i <= 8; i++) cyc(1, 0, 8'(i * 17), 0);
        cyc(1, 0, 8'h99, 0);
        cyc(0, 0, 8'h00, 0);
        // drain 8, then one read while empty
        for (int i = 0; i < 9; i++) cyc(0, 1, 8'h00, 0);
        cyc(0, 0, 8'h00, 0);
        // prefill 3, then continuous write+read across pointer wraps
        for (int i = 0; i < 3; i++) cyc(1, 0, 8'(8'hA0 + i), 0);
        for (int i = 0; i < 20; i++) cyc(1, 1, 8'(8'hB0 + i), 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 8'h00, 0);
        // mid-operation reset with a concurrent write
        for (int i = 0; i < 5; i++) cyc(1, 0, 8'(8'h30 + i), 0);
        cyc(1, 0, 8'hEE, 1);
        cyc(1, 0, 8'h5A, 0);
        cyc(0, 1, 8'h00, 0);
        cyc(0, 0, 8'h00, 0);
        // simultaneous write+read when empty, then when full
        cyc(1, 1, 8'h61, 0);
        for (int i = 0; i < 7; i++) cyc(1, 0, 8'(8'h70 + i), 0);
        cyc(1, 1, 8'h7F, 0);
        cyc(0, 0, 8'h00, 0);
        for (int i = 0; i < 9; i++) cyc(0, 1, 8'h00, 0);
        // randomized traffic with varying bias and rare resets
        wp = 50; rp = 50;
        for (int i = 0; i < 2000; i++) begin
            if (i % 100 == 0) begin
                wp = $urandom_range(10, 90);
                rp = $urandom_range(10, 90);
            end
            cyc($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
                8'($urandom), $urandom_range(0, 299) == 0);
        end
        for (int i = 0; i < 10; i++) cyc(0, 1, 8'h00, 0);
        cyc(0, 0, 8'h00, 0);
        cyc(0, 0, 8'h00, 0);
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) chk("sb_drain", d, sb[d].size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, nerr);
        $finish;
    end
endmodule
